// File: rtl/uart_axil_fifo_slave.sv
// AXI4-Lite UART register slave: TX/RX byte FIFOs, sticky overflow flags,
// interrupt enables and a registered interrupt level.

module uart_axil_fifo_slave_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       empty_nx,
  output logic       drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, rp_q;
  logic [7:0]    mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign drop     = push & full;
  assign dout     = mem_q[rp_q];
  assign empty_nx = (cnt_d == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok & ~pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok & ~push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din;
  end
endmodule

module uart_axil_fifo_slave #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst,
  input  logic [ADDR_WIDTH-1:0] uart_axi_awaddr,
  input  logic                  uart_axi_awvalid,
  output logic                  uart_axi_awready,
  input  logic [31:0]           uart_axi_wdata,
  input  logic                  uart_axi_wvalid,
  output logic                  uart_axi_wready,
  output logic [1:0]            uart_axi_bresp,
  output logic                  uart_axi_bvalid,
  input  logic                  uart_axi_bready,
  input  logic [ADDR_WIDTH-1:0] uart_axi_araddr,
  input  logic                  uart_axi_arvalid,
  output logic                  uart_axi_arready,
  output logic [31:0]           uart_axi_rdata,
  output logic [1:0]            uart_axi_rresp,
  output logic                  uart_axi_rvalid,
  input  logic                  uart_axi_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  uart_irq
);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:2] aw_addr_q, w_addr;
  logic [7:0]            w_data_q, w_byte;
  logic [1:0]            bresp_q, rresp_q, ie_q, ie_d;
  logic [31:0]           rdata_q, rdata_nx;
  logic                  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, irq_q;
  logic                  aw_hs, w_hs, ar_hs, do_write;
  logic                  w_mapped, r_mapped;
  logic [1:0]            w_sel, r_sel;
  logic                  tx_push, tx_pop, tx_empty, tx_full, tx_empty_nx, tx_drop;
  logic                  rx_pop, rx_empty, rx_full, rx_empty_nx, rx_drop;
  logic [7:0]            rx_head;
  logic                  st_wr, ie_wr;
  logic                  unused_bits;

  assign unused_bits = ^{uart_axi_awaddr[1:0], uart_axi_araddr[1:0], uart_axi_wdata[31:8]};

  // Readies are held low while reset is asserted so nothing is accepted mid-reset.
  assign uart_axi_awready = (w_state_q == W_IDLE) & ~aw_held_q & ~chipset_rst;
  assign uart_axi_wready  = (w_state_q == W_IDLE) & ~w_held_q & ~chipset_rst;
  assign uart_axi_arready = (r_state_q == R_IDLE) & ~chipset_rst;
  assign uart_axi_bvalid  = (w_state_q == W_RESP);
  assign uart_axi_rvalid  = (r_state_q == R_DATA);
  assign uart_axi_bresp   = bresp_q;
  assign uart_axi_rresp   = rresp_q;
  assign uart_axi_rdata   = rdata_q;
  assign uart_irq         = irq_q;

  assign aw_hs = uart_axi_awvalid & uart_axi_awready;
  assign w_hs  = uart_axi_wvalid & uart_axi_wready;
  assign ar_hs = uart_axi_arvalid & uart_axi_arready;

  // Same-cycle handshakes use the live bus values, otherwise the held copies.
  assign w_addr   = aw_held_q ? aw_addr_q : uart_axi_awaddr[ADDR_WIDTH-1:2];
  assign w_byte   = w_held_q ? w_data_q : uart_axi_wdata[7:0];
  assign w_mapped = (w_addr[ADDR_WIDTH-1:4] == '0);
  assign w_sel    = w_addr[3:2];
  assign r_mapped = (uart_axi_araddr[ADDR_WIDTH-1:4] == '0);
  assign r_sel    = uart_axi_araddr[3:2];

  assign tx_push = do_write & w_mapped & (w_sel == 2'd0);
  assign st_wr   = do_write & w_mapped & (w_sel == 2'd2);
  assign ie_wr   = do_write & w_mapped & (w_sel == 2'd3);
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_pop  = ar_hs & r_mapped & (r_sel == 2'd1);
  assign tx_valid = ~tx_empty;

  assign tx_ovf_d = (tx_ovf_q & ~(st_wr & w_byte[4])) | tx_drop;
  assign rx_ovf_d = (rx_ovf_q & ~(st_wr & w_byte[5])) | rx_drop;
  assign ie_d     = ie_wr ? w_byte[1:0] : ie_q;

  uart_axil_fifo_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(chipset_clk), .rst(chipset_rst), .push(tx_push), .din(w_byte), .pop(tx_pop),
    .dout(tx_data), .empty(tx_empty), .full(tx_full), .empty_nx(tx_empty_nx), .drop(tx_drop)
  );

  uart_axil_fifo_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(chipset_clk), .rst(chipset_rst), .push(rx_valid), .din(rx_data), .pop(rx_pop),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .empty_nx(rx_empty_nx), .drop(rx_drop)
  );

  always_comb begin
    rdata_nx = 32'h0;
    if (r_mapped) begin
      case (r_sel)
        2'd1:    rdata_nx = rx_empty ? 32'h8000_0000 : {24'h0, rx_head};
        2'd2:    rdata_nx = {26'h0, rx_ovf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
        2'd3:    rdata_nx = {30'h0, ie_q};
        default: rdata_nx = 32'h0;
      endcase
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    do_write  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
          do_write  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (uart_axi_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (uart_axi_rready) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
      ie_q      <= 2'b00;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      if (aw_hs) aw_addr_q <= uart_axi_awaddr[ADDR_WIDTH-1:2];
      if (w_hs)  w_data_q  <= uart_axi_wdata[7:0];
      if (do_write) bresp_q <= w_mapped ? 2'b00 : 2'b10;
      if (ar_hs) begin
        rdata_q <= rdata_nx;
        rresp_q <= r_mapped ? 2'b00 : 2'b10;
      end
      ie_q     <= ie_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      // Interrupt follows the FIFO occupancy as it will be after this edge.
      irq_q    <= (ie_d[0] & ~rx_empty_nx) | (ie_d[1] & tx_empty_nx);
    end
  end
endmodule

// File: tb/tb_uart_axil_fifo_slave.sv
// Directed bench for uart_axil_fifo_slave with queue-based expected responses.

module tb_uart_axil_fifo_slave;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [1:0]  bresp, rresp;
  logic [7:0]  tx_data, rx_data = '0;
  logic        tx_valid, tx_ready = 0, rx_valid = 0, uart_irq;

  int checks = 0;
  int errors = 0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];

  always #5 clk = ~clk;

  uart_axil_fifo_slave #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(13)) dut (
    .chipset_clk(clk), .chipset_rst(rst),
    .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
    .uart_axi_wdata(wdata), .uart_axi_wvalid(wvalid), .uart_axi_wready(wready),
    .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready),
    .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
    .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid),
    .uart_axi_rready(rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .uart_irq(uart_irq)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_collect(input string tag);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin tick(); n++; end
    chk(tag, {bvalid, bresp}, {1'b1, bq.pop_front()});
    tick();
    bready = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d);
    logic af, wf;
    bq.push_back((a[12:4] == 0) ? 2'b00 : 2'b10);
    if (a[12:4] == 0 && a[3:2] == 2'd0 && txq.size() < DEPTH) txq.push_back(d[7:0]);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 50 && (awvalid || wvalid); n++) begin
      af = awvalid & awready;
      wf = wvalid & wready;
      tick();
      if (af) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    b_collect("bresp");
  endtask

  task automatic rd_issue(input logic [12:0] a);
    logic f;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      f = arready;
      tick();
      if (f) break;
    end
    arvalid = 1'b0;
  endtask

  task automatic rd_collect(input string tag);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 50) begin tick(); n++; end
    chk(tag, {rvalid, rresp, rdata}, {1'b1, rq.pop_front()});
    tick();
    rready = 1'b0;
  endtask

  // reg_exp supplies the value for STATUS/IE; RXDATA comes from the RX model.
  task automatic rd(input logic [12:0] a, input string tag, input logic [31:0] reg_exp);
    logic [31:0] e;
    if (a[12:4] != 0) rq.push_back({2'b10, 32'h0});
    else begin
      case (a[3:2])
        2'd0:    e = 32'h0;
        2'd1:    e = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h8000_0000;
        default: e = reg_exp;
      endcase
      rq.push_back({2'b00, e});
    end
    rd_issue(a);
    rd_collect(tag);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    if (rxq.size() < DEPTH) rxq.push_back(d);
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("ready_in_reset", {awready, wready, arready}, 3'b000);
    rst = 1'b0;
    tick(); tick();
    chk("post_reset", {awready, wready, arready, bvalid, rvalid, tx_valid, uart_irq}, 7'b1110000);
    rd(13'h008, "status_reset", 32'h0A);

    // AW three cycles ahead of W; byte drains immediately with tx_ready high.
    tx_ready = 1'b1;
    awaddr = 13'h000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_held", {awready, wready, bvalid}, 3'b010);
    tick(); tick();
    wdata = 32'h41; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("b_after_w", {bvalid, bresp, tx_valid, tx_data}, {1'b1, 2'b00, 1'b1, 8'h41});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("tx_one_cycle", {bvalid, tx_valid}, 2'b00);

    // TX overflow: 17 writes into 16 entries.
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) wr(13'h000, i);
    rd(13'h008, "status_tx_full", 32'h19);
    tx_ready = 1'b1;
    for (int k = 0; k < 40 && txq.size() > 0; k++) begin
      if (tx_valid) chk("tx_drain", tx_data, txq.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_drain_left", txq.size(), 0);
    wr(13'h008, 32'h10);
    rd(13'h008, "status_tx_clr", 32'h0A);

    rx_push(8'hA1); rx_push(8'hB2); rx_push(8'hC3);
    for (int i = 0; i < 4; i++) rd(13'h004, "rxdata", 32'h0);

    // RX-not-empty interrupt.
    wr(13'h00C, 32'h1);
    rd(13'h00C, "ie_read", 32'h1);
    rx_push(8'h5A);
    chk("irq_rise", uart_irq, 1'b1);
    tick();
    chk("irq_hold", uart_irq, 1'b1);
    rq.push_back({2'b00, 24'h0, rxq.pop_front()});
    rd_issue(13'h004);
    chk("irq_drop", uart_irq, 1'b0);
    rd_collect("rx_irq_byte");

    wr(13'h010, 32'h41);
    rd(13'h010, "unmapped_rd", 32'h0);
    chk("unmapped_no_push", tx_valid, 1'b0);
    rd(13'h008, "status_unmapped", 32'h0A);

    // RX full with simultaneous push and pop: push dropped, pop happens.
    for (int i = 0; i < DEPTH; i++) rx_push(8'h10 + 8'(i));
    rd(13'h008, "status_rx_full", 32'h06);
    rq.push_back({2'b00, 24'h0, rxq.pop_front()});
    rx_data = 8'hEE; rx_valid = 1'b1;
    araddr = 13'h004; arvalid = 1'b1;
    tick();
    rx_valid = 1'b0; arvalid = 1'b0;
    rd_collect("rx_pop_full");
    rd(13'h008, "status_rx_ovf", 32'h22);
    for (int i = 0; i < DEPTH; i++) rd(13'h004, "rx_drain", 32'h0);

    // TXDATA write and STATUS read on the same edge see pre-edge state.
    wr(13'h008, 32'h20);
    awaddr = 13'h000; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 13'h008; arvalid = 1'b1;
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h0A});
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rd_collect("status_pre_edge");
    b_collect("bresp_concurrent");
    chk("tx_concurrent", {tx_valid, tx_data}, {1'b1, 8'h77});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_concurrent_pop", tx_valid, 1'b0);

    // Reset while a write response is pending.
    awaddr = 13'h000; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_before_reset", bvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("reset_abort", {bvalid, tx_valid, awready, wready, arready, uart_irq}, 6'b001110);
    rd(13'h00C, "ie_after_reset", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
